iq_mod: RTL and testbench
=========================

Name: iq_mod

Overview:
- Transmit-side IF upconverter, the counterpart of the receive IQ demodulator.
- Accepts signed baseband I/Q samples through a valid/ready handshake and buffers them in a 2-entry FIFO.
- On each DAC conversion tick, pops one sample and mixes it with an internal 8-point cos/sin NCO.
- Requantizes and saturates the result, then drives 4-bit offset-binary I/Q codes to the DAC with a one-cycle load strobe.

Parameters:
- BB_W, 8: signed baseband sample width.
- IF_W, 4: DAC code width (offset binary).
- SHIFT, 6: arithmetic right shift applied to the mixer sums before saturation.
- PHASE_STEP, 1: NCO phase increment per tick, modulo 8. 1 gives IF = fs/8.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_I_bb  in  BB_W  signed baseband I.
- i_Q_bb  in  BB_W  signed baseband Q.
- i_valid  in  1  baseband sample valid.
- o_ready  out  1  FIFO not full.
- i_dac_tick  in  1  one-cycle pulse requesting the next DAC sample; synchronous to i_clk.
- i_clr_flags  in  1  clears the sticky flags.
- o_I_if  out  IF_W  I DAC code, offset binary.
- o_Q_if  out  IF_W  Q DAC code, offset binary.
- o_dac_load  out  1  one-cycle strobe; codes are new this cycle.
- o_underrun  out  1  sticky: a tick found the FIFO empty.
- o_tick_err  out  1  sticky: a tick arrived while the block was busy.

Behaviour:
- Reset (async, any time, including mid-operation): all state is cleared.
  - FIFO empty, phase = 0, FSM in IDLE.
  - o_I_if = o_Q_if = 2^(IF_W-1) (code 8, the zero level).
  - o_dac_load = 0, both flags = 0, o_ready = 1 the first cycle after release.
- FIFO: 2 entries.
  - Push when i_valid & o_ready.
  - o_ready = (count < 2), registered from count.
  - A push and a pop in the same cycle leave count unchanged.
  - No bypass: a sample pushed in the tick cycle is not visible to that tick's pop.
- NCO LUT (signed 4-bit), indexed by phase 0..7:
  - cos = 7, 5, 0, -5, -7, -5, 0, 5
  - sin = 0, 5, 7, 5, 0, -5, -7, -5
- FSM states: IDLE, MIX, LOAD.
  - IDLE: on i_dac_tick, capture the FIFO head (pop if count > 0), else capture I = Q = 0 and set o_underrun. Latch the current phase. Go to MIX.
  - MIX: register the products and sums. Go to LOAD.
  - LOAD: update o_I_if / o_Q_if, pulse o_dac_load, phase <= (phase + PHASE_STEP) mod 8. Go to IDLE.
- Latency: tick in cycle T gives new codes and o_dac_load=1 in cycle T+2. Minimum tick spacing is 3 cycles.
- i_dac_tick while in MIX or LOAD: the tick is dropped, o_tick_err is set, and phase does not advance.
- The phase advances on underrun ticks, so the carrier stays continuous.
- Arithmetic:
  - Products are BB_W+4 bits signed.
  - I_mix = I*cos - Q*sin; Q_mix = I*sin + Q*cos; each BB_W+5 bits signed.
  - Each sum is shifted right arithmetically by SHIFT (floor).
  - Result is saturated to [-2^(IF_W-1), 2^(IF_W-1)-1], then 2^(IF_W-1) is added to form the offset-binary code.
- Outputs hold their value between loads.
- Flags: sticky until i_clr_flags. If i_clr_flags and a new flag event occur in the same cycle, the event wins (flag = 1).

Test Plan:
- Reset mid-MIX with 2 samples queued -> next cycle: codes 8/8, o_dac_load=0, o_ready=1, flags 0; first subsequent tick produces an underrun.
- Push I=64, Q=0 once per tick; ticks every 4 cycles, 8 ticks -> o_I_if = 15,13,8,3,1,3,8,13 and o_Q_if = 8,13,15,13,8,3,1,3; o_dac_load exactly at T+2.
- Push I=127, Q=-128 at phase 1 -> I_mix = 1275 saturates to code 15; Q_mix = -5 >>> 6 = -1 gives code 7.
- Push 3 samples back-to-back with no ticks -> o_ready deasserts after the 2nd; 3rd held on i_valid until the first pop, then accepted.
- Tick with FIFO empty -> codes 8/8, o_dac_load pulses, o_underrun=1, phase advances; i_clr_flags clears it.
- Ticks at T and T+1 -> second tick dropped, o_tick_err=1, exactly one o_dac_load, phase advances by one step only.

Source files
------------

// File: rtl/iq_mod.sv
// ---------------------------------------------------------------------------
// iq_mod -- transmit-side IF upconverter.
//
// Baseband I/Q samples enter through a valid/ready handshake into a 2-entry
// FIFO. Each DAC tick pops one sample (or zero on underrun) and mixes it with
// an 8-point cos/sin NCO. The mixer sums are requantized, saturated and
// presented to the DAC as offset-binary codes with a one-cycle load strobe.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_I_bb       signed baseband I sample (BB_W)
//   i_Q_bb       signed baseband Q sample (BB_W)
//   i_valid      baseband sample valid
//   o_ready      FIFO not full (registered)
//   i_dac_tick   one-cycle request for the next DAC sample
//   i_clr_flags  clears the sticky flags
//   o_I_if       I DAC code, offset binary (IF_W)
//   o_Q_if       Q DAC code, offset binary (IF_W)
//   o_dac_load   one-cycle strobe, codes are new this cycle
//   o_underrun   sticky: a tick found the FIFO empty
//   o_tick_err   sticky: a tick arrived while busy
// ---------------------------------------------------------------------------
module iq_mod #(
    parameter int BB_W       = 8,
    parameter int IF_W       = 4,
    parameter int SHIFT      = 6,
    parameter int PHASE_STEP = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic signed [BB_W-1:0] i_I_bb,
    input  logic signed [BB_W-1:0] i_Q_bb,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_dac_tick,
    input  logic                   i_clr_flags,
    output logic [IF_W-1:0]        o_I_if,
    output logic [IF_W-1:0]        o_Q_if,
    output logic                   o_dac_load,
    output logic                   o_underrun,
    output logic                   o_tick_err
);

    localparam int PROD_W = BB_W + 4;
    localparam int MIX_W  = BB_W + 5;

    localparam logic signed [MIX_W-1:0] SAT_MAX   = MIX_W'(2**(IF_W-1) - 1);
    localparam logic signed [MIX_W-1:0] SAT_MIN   = MIX_W'(-(2**(IF_W-1)));
    localparam logic [IF_W-1:0]         CODE_ZERO = IF_W'(2**(IF_W-1));
    localparam logic [2:0]              PH_STEP   = 3'(PHASE_STEP % 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // NCO cosine table, amplitude 7
    function automatic logic signed [3:0] lut_cos(input logic [2:0] ph);
        logic signed [3:0] v;
        case (ph)
            3'd0:    v = 4'sd7;
            3'd1:    v = 4'sd5;
            3'd2:    v = 4'sd0;
            3'd3:    v = -4'sd5;
            3'd4:    v = -4'sd7;
            3'd5:    v = -4'sd5;
            3'd6:    v = 4'sd0;
            3'd7:    v = 4'sd5;
            default: v = 4'sd0;
        endcase
        return v;
    endfunction

    // NCO sine table, amplitude 7
    function automatic logic signed [3:0] lut_sin(input logic [2:0] ph);
        logic signed [3:0] v;
        case (ph)
            3'd0:    v = 4'sd0;
            3'd1:    v = 4'sd5;
            3'd2:    v = 4'sd7;
            3'd3:    v = 4'sd5;
            3'd4:    v = 4'sd0;
            3'd5:    v = -4'sd5;
            3'd6:    v = -4'sd7;
            3'd7:    v = -4'sd5;
            default: v = 4'sd0;
        endcase
        return v;
    endfunction

    // Floor shift, saturate to the DAC range, then bias to offset binary
    function automatic logic [IF_W-1:0] to_code(input logic signed [MIX_W-1:0] mix);
        logic signed [MIX_W-1:0] sh;
        logic signed [MIX_W-1:0] sat;
        sh = mix >>> SHIFT;
        if (sh > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (sh < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = sh;
        end
        return sat[IF_W-1:0] + CODE_ZERO;
    endfunction

    state_t                 state_r;
    logic signed [BB_W-1:0] mem_i_r [2];
    logic signed [BB_W-1:0] mem_q_r [2];
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;
    logic [1:0]             count_r;
    logic                   ready_r;
    logic signed [BB_W-1:0] cap_i_r;
    logic signed [BB_W-1:0] cap_q_r;
    logic [2:0]             ph_lat_r;
    logic [2:0]             phase_r;
    logic [IF_W-1:0]        i_if_r;
    logic [IF_W-1:0]        q_if_r;
    logic                   load_r;
    logic                   underrun_r;
    logic                   tick_err_r;

    logic                     push_s;
    logic                     pop_s;
    logic                     tick_idle_s;
    logic [1:0]               count_nxt_s;
    logic signed [3:0]        cos_s;
    logic signed [3:0]        sin_s;
    logic signed [PROD_W-1:0] ext_i_s;
    logic signed [PROD_W-1:0] ext_q_s;
    logic signed [PROD_W-1:0] ext_cos_s;
    logic signed [PROD_W-1:0] ext_sin_s;
    logic signed [PROD_W-1:0] p_ic_s;
    logic signed [PROD_W-1:0] p_qs_s;
    logic signed [PROD_W-1:0] p_is_s;
    logic signed [PROD_W-1:0] p_qc_s;
    logic signed [MIX_W-1:0]  i_mix_s;
    logic signed [MIX_W-1:0]  q_mix_s;

    assign push_s      = i_valid & ready_r;
    assign tick_idle_s = i_dac_tick & (state_r == ST_IDLE);
    // Pop uses the registered count, so a same-cycle push is never bypassed
    assign pop_s       = tick_idle_s & (count_r != 2'd0);

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Mixer datapath: sign-extend operands to product width, then combine
    always_comb begin
        cos_s     = lut_cos(ph_lat_r);
        sin_s     = lut_sin(ph_lat_r);
        ext_i_s   = {{4{cap_i_r[BB_W-1]}}, cap_i_r};
        ext_q_s   = {{4{cap_q_r[BB_W-1]}}, cap_q_r};
        ext_cos_s = {{BB_W{cos_s[3]}}, cos_s};
        ext_sin_s = {{BB_W{sin_s[3]}}, sin_s};
        p_ic_s    = ext_i_s * ext_cos_s;
        p_qs_s    = ext_q_s * ext_sin_s;
        p_is_s    = ext_i_s * ext_sin_s;
        p_qc_s    = ext_q_s * ext_cos_s;
        i_mix_s   = $signed({p_ic_s[PROD_W-1], p_ic_s}) - $signed({p_qs_s[PROD_W-1], p_qs_s});
        q_mix_s   = $signed({p_is_s[PROD_W-1], p_is_s}) + $signed({p_qc_s[PROD_W-1], p_qc_s});
    end

    // FIFO storage, pointers, count and registered ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_i_r[0] <= '0;
            mem_i_r[1] <= '0;
            mem_q_r[0] <= '0;
            mem_q_r[1] <= '0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            ready_r    <= 1'b1;
        end else begin
            if (push_s) begin
                mem_i_r[wr_ptr_r] <= i_I_bb;
                mem_q_r[wr_ptr_r] <= i_Q_bb;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < 2'd2);
        end
    end

    // Tick sequencer: capture -> mix/requantize -> load strobe and phase step.
    // Codes are registered on the MIX->LOAD edge so they appear with the
    // strobe two cycles after the tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            cap_i_r  <= '0;
            cap_q_r  <= '0;
            ph_lat_r <= 3'd0;
            phase_r  <= 3'd0;
            i_if_r   <= CODE_ZERO;
            q_if_r   <= CODE_ZERO;
            load_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    load_r <= 1'b0;
                    if (i_dac_tick) begin
                        if (count_r != 2'd0) begin
                            cap_i_r <= mem_i_r[rd_ptr_r];
                            cap_q_r <= mem_q_r[rd_ptr_r];
                        end else begin
                            cap_i_r <= '0;
                            cap_q_r <= '0;
                        end
                        ph_lat_r <= phase_r;
                        state_r  <= ST_MIX;
                    end
                end
                ST_MIX: begin
                    i_if_r  <= to_code(i_mix_s);
                    q_if_r  <= to_code(q_mix_s);
                    load_r  <= 1'b1;
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    load_r  <= 1'b0;
                    phase_r <= phase_r + PH_STEP;
                    state_r <= ST_IDLE;
                end
                default: begin
                    load_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags; a new event takes priority over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            underrun_r <= 1'b0;
            tick_err_r <= 1'b0;
        end else begin
            if (tick_idle_s && (count_r == 2'd0)) begin
                underrun_r <= 1'b1;
            end else if (i_clr_flags) begin
                underrun_r <= 1'b0;
            end
            if (i_dac_tick && (state_r != ST_IDLE)) begin
                tick_err_r <= 1'b1;
            end else if (i_clr_flags) begin
                tick_err_r <= 1'b0;
            end
        end
    end

    assign o_ready    = ready_r;
    assign o_I_if     = i_if_r;
    assign o_Q_if     = q_if_r;
    assign o_dac_load = load_r;
    assign o_underrun = underrun_r;
    assign o_tick_err = tick_err_r;

endmodule

// File: tb/tb_iq_mod.sv
// ---------------------------------------------------------------------------
// tb_iq_mod -- self-checking bench for iq_mod.
// Expected codes and their due cycle are queued when a tick is driven; a
// monitor pops them on every o_dac_load and also checks that codes hold
// between loads.
// ---------------------------------------------------------------------------
module tb_iq_mod;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic signed [7:0] i_I_bb;
    logic signed [7:0] i_Q_bb;
    logic              i_valid;
    logic              o_ready;
    logic              i_dac_tick;
    logic              i_clr_flags;
    logic [3:0]        o_I_if;
    logic [3:0]        o_Q_if;
    logic              o_dac_load;
    logic              o_underrun;
    logic              o_tick_err;

    iq_mod #(.BB_W(8), .IF_W(4), .SHIFT(6), .PHASE_STEP(1)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_I_bb      (i_I_bb),
        .i_Q_bb      (i_Q_bb),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dac_tick  (i_dac_tick),
        .i_clr_flags (i_clr_flags),
        .o_I_if      (o_I_if),
        .o_Q_if      (o_Q_if),
        .o_dac_load  (o_dac_load),
        .o_underrun  (o_underrun),
        .o_tick_err  (o_tick_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic signed [7:0] si;
        logic signed [7:0] sq;
        logic [3:0]        ei;
        logic [3:0]        eq;
    } vec_t;

    typedef struct {
        logic [3:0] ei;
        logic [3:0] eq;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[12];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [3:0] last_i = 4'd8;
    logic [3:0] last_q = 4'd8;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Entered and left at a negedge; holds valid until the sample is taken
    task automatic push_sample(input logic signed [7:0] si, input logic signed [7:0] sq);
        int n;
        n = 0;
        i_I_bb  = si;
        i_Q_bb  = sq;
        i_valid = 1'b1;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) begin
            check("push_timeout", 0, 1);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // One-cycle tick with a queued expectation for the load two cycles later
    task automatic do_tick(input logic [3:0] ei, input logic [3:0] eq);
        exp_t e;
        e.ei  = ei;
        e.eq  = eq;
        e.due = cyc + 2;
        sb_q.push_back(e);
        i_dac_tick = 1'b1;
        @(negedge i_clk);
        i_dac_tick = 1'b0;
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Output monitor: scoreboard pop on load, hold check otherwise
    initial forever begin
        exp_t e;
        @(negedge i_clk);
        if (!i_rst_n) begin
            last_i = 4'd8;
            last_q = 4'd8;
        end else if (o_dac_load) begin
            if (sb_q.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("load_cycle", cyc, e.due);
                check("code_I", int'(o_I_if), int'(e.ei));
                check("code_Q", int'(o_Q_if), int'(e.eq));
                last_i = e.ei;
                last_q = e.eq;
            end
        end else begin
            check("hold_I", int'(o_I_if), int'(last_i));
            check("hold_Q", int'(o_Q_if), int'(last_q));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'sd64,   8'sd0,   4'd15, 4'd8};
        tbl[1]  = '{8'sd64,   8'sd0,   4'd13, 4'd13};
        tbl[2]  = '{8'sd64,   8'sd0,   4'd8,  4'd15};
        tbl[3]  = '{8'sd64,   8'sd0,   4'd3,  4'd13};
        tbl[4]  = '{8'sd64,   8'sd0,   4'd1,  4'd8};
        tbl[5]  = '{8'sd64,   8'sd0,   4'd3,  4'd3};
        tbl[6]  = '{8'sd64,   8'sd0,   4'd8,  4'd1};
        tbl[7]  = '{8'sd64,   8'sd0,   4'd13, 4'd3};
        tbl[8]  = '{-8'sd100, 8'sd50,  4'd0,  4'd13};
        tbl[9]  = '{8'sd127,  8'sh80,  4'd15, 4'd7};
        tbl[10] = '{8'sd10,   -8'sd20, 4'd10, 4'd9};
        tbl[11] = '{-8'sd1,   8'sd0,   4'd8,  4'd7};

        i_rst_n     = 1'b0;
        i_I_bb      = 8'sd0;
        i_Q_bb      = 8'sd0;
        i_valid     = 1'b0;
        i_dac_tick  = 1'b0;
        i_clr_flags = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_I", int'(o_I_if), 8);
        check("rst_Q", int'(o_Q_if), 8);
        check("rst_load", int'(o_dac_load), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_underrun", int'(o_underrun), 0);
        check("rst_tick_err", int'(o_tick_err), 0);

        // Table: one sample then one tick each; phase equals index mod 8
        for (int k = 0; k < 12; k++) begin
            push_sample(tbl[k].si, tbl[k].sq);
            do_tick(tbl[k].ei, tbl[k].eq);
            repeat (3) @(negedge i_clk);
        end
        check("table_underrun", int'(o_underrun), 0);
        check("table_tick_err", int'(o_tick_err), 0);

        // Backpressure: three back-to-back samples, phase 4
        i_I_bb  = 8'sd64;
        i_Q_bb  = 8'sd0;
        i_valid = 1'b1;
        @(negedge i_clk);
        check("bp_ready_after_1", int'(o_ready), 1);
        i_I_bb = 8'sd0;
        i_Q_bb = 8'sd64;
        @(negedge i_clk);
        check("bp_ready_after_2", int'(o_ready), 0);
        i_I_bb = -8'sd64;
        i_Q_bb = 8'sd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            check("bp_ready_held", int'(o_ready), 0);
        end
        do_tick(4'd1, 4'd8);
        check("bp_ready_after_pop", int'(o_ready), 1);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("bp_ready_after_3rd", int'(o_ready), 0);
        repeat (2) @(negedge i_clk);
        do_tick(4'd13, 4'd3);
        repeat (3) @(negedge i_clk);
        do_tick(4'd8, 4'd15);
        repeat (3) @(negedge i_clk);

        // Underrun at phase 7, then clear, then event-wins over clear
        do_tick(4'd8, 4'd8);
        check("underrun_set", int'(o_underrun), 1);
        check("underrun_no_tick_err", int'(o_tick_err), 0);
        repeat (3) @(negedge i_clk);
        i_clr_flags = 1'b1;
        @(negedge i_clk);
        i_clr_flags = 1'b0;
        check("underrun_cleared", int'(o_underrun), 0);
        i_clr_flags = 1'b1;
        do_tick(4'd8, 4'd8);
        i_clr_flags = 1'b0;
        check("underrun_beats_clear", int'(o_underrun), 1);
        repeat (3) @(negedge i_clk);
        push_sample(8'sd64, 8'sd0);
        do_tick(4'd13, 4'd13);
        repeat (3) @(negedge i_clk);

        // Ticks at T and T+1 at phase 2: one load, one phase step
        push_sample(8'sd64, 8'sd0);
        begin
            exp_t e;
            e.ei  = 4'd8;
            e.eq  = 4'd15;
            e.due = cyc + 2;
            sb_q.push_back(e);
        end
        i_dac_tick = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_dac_tick = 1'b0;
        check("tick_err_set", int'(o_tick_err), 1);
        repeat (3) @(negedge i_clk);
        push_sample(8'sd64, 8'sd0);
        do_tick(4'd3, 4'd13);
        repeat (3) @(negedge i_clk);
        i_clr_flags = 1'b1;
        @(negedge i_clk);
        i_clr_flags = 1'b0;
        check("tick_err_cleared", int'(o_tick_err), 0);
        check("underrun_cleared_2", int'(o_underrun), 0);

        // Set underrun (phase 4), then reset mid-MIX with two samples queued
        do_tick(4'd8, 4'd8);
        repeat (3) @(negedge i_clk);
        push_sample(8'sd100, 8'sd20);
        push_sample(-8'sd50, 8'sd30);
        i_dac_tick = 1'b1;
        @(negedge i_clk);
        i_dac_tick = 1'b0;
        i_rst_n    = 1'b0;
        #1;
        check("async_rst_I", int'(o_I_if), 8);
        check("async_rst_Q", int'(o_Q_if), 8);
        check("async_rst_ready", int'(o_ready), 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst2_I", int'(o_I_if), 8);
        check("rst2_Q", int'(o_Q_if), 8);
        check("rst2_load", int'(o_dac_load), 0);
        check("rst2_ready", int'(o_ready), 1);
        check("rst2_underrun", int'(o_underrun), 0);
        check("rst2_tick_err", int'(o_tick_err), 0);
        do_tick(4'd8, 4'd8);
        check("rst2_first_tick_underrun", int'(o_underrun), 1);
        repeat (3) @(negedge i_clk);
        push_sample(8'sd64, 8'sd0);
        do_tick(4'd13, 4'd13);
        repeat (5) @(negedge i_clk);

        check("pending_loads", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
